rggen_bit_field_sticky_event: RTL
=================================

# rggen_bit_field_sticky_event

Multi-channel sticky event-flag bit field for rggen-generated register blocks. Each bit latches a hardware event selected by a configurable edge or level mode, and software clears it by writing a configurable clear value. Each bit also records overflow, meaning an event that arrived while its flag was already set. It connects to the register through `rggen_bit_field_if` and drives a registered, maskable interrupt.

## Interface
- `WIDTH`, default 1: number of event channels (bits).
- `EVENT_MODE`, default `RGGEN_EVENT_RISING`: detection mode (`rggen_event_mode`), applied to all channels.
- `CLEAR_VALUE`, default 1'b1: write-data value that clears a flag (1 = W1C, 0 = W0C).
- `INITIAL_VALUE`, default '0: reset value of the flags.
- `clk` input 1: clock clk.
- `rst_n` input 1: reset rst_n, asynchronous, active-low.
- `i_event` input WIDTH: raw hardware event inputs.
- `i_irq_mask` input WIDTH: 1 = channel enabled for interrupt.
- `bit_field_if` modport slave: register access; uses `write_access`, `write_data`, `write_mask`; drives `value` and `read_data`.
- `o_value` output WIDTH: current flags.
- `o_overflow` output WIDTH: per-channel overflow flags.
- `o_irq` output 1: registered interrupt.

## Operation
- Per-channel detector outputs a one-cycle hit:
  - LEVEL: hit = `ev`.
  - RISING: hit = `ev & ~prev`.
  - FALLING: hit = `~ev & prev`.
  - BOTH: hit = `ev ^ prev`.
  - `prev` is the registered `ev` and resets to 0. An input held high at reset release therefore gives a RISING/BOTH hit on the first active edge.
- Clear vector: `clr = write_access ? write_mask & (CLEAR_VALUE ? write_data : ~write_data) : '0`.
- Next flag: `hit | (flag & ~clr)`. A hit and a clear in the same cycle leave the flag set, so the event is never lost.
- Next overflow: `(hit & flag & ~clr) | (ovf & ~clr)`. The clear wins for the overflow bit.
- Overflow is not set on a hit in the same cycle as a clear, because the new event is now counted in the flag.
- Per-channel state: IDLE (flag 0) → PENDING on hit → OVERFLOW on hit while PENDING. Clear takes any state to IDLE, or to PENDING if a hit coincides.
- `bit_field_if.value[WIDTH-1:0]`, `read_data[WIDTH-1:0]` and `o_value` all show the flags.
- Writes with `write_mask` = 0 have no effect. Read access has no side effects.
- `o_irq <= |(next_flag & i_irq_mask)`, registered.

## Timing
- Reset values: flags = `INITIAL_VALUE`, overflow = '0, `prev` = '0, `o_irq` = 0. `o_irq` then updates on the first clock.
- Event latency from `i_event` change to flag: 1 cycle without synchronizer, 3 cycles with it.
- `o_irq` asserts in the same cycle the flag becomes visible.
- Clear latency: 1 cycle after the write cycle.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

## Configuration
- `RGGEN_STICKY_EVENT_SYNC_EN` defined: each `i_event` bit passes through a 2-flop synchronizer (reset 0) before the detector. Use this for asynchronous sources.
- Macro undefined: `i_event` is sampled directly and must be synchronous to `clk`.

## Structure
- `rggen_rtl_pkg`: add `typedef enum logic [1:0] {RGGEN_EVENT_LEVEL, RGGEN_EVENT_RISING, RGGEN_EVENT_FALLING, RGGEN_EVENT_BOTH} rggen_event_mode;`.
- Sub-module `rggen_event_detector`, parameters `EVENT_MODE` and `WIDTH`:
  - contains the optional synchronizer and the `prev` register;
  - outputs the hit vector.
- Top module holds the flag, overflow and irq registers.

## Test plan
- WIDTH=4, RISING, W1C: pulse `i_event[2]` 0→1 → `o_value`=4'b0100 next cycle. With `i_irq_mask`=4'b0100, `o_irq`=1 in the same cycle. Write data 4'b0100, mask 4'hF → `o_value`=0 and `o_irq`=0.
- Second rising edge on bit 2 while flag set → `o_overflow`=4'b0100. One W1C of bit 2 → both flag and overflow are 0.
- Hit on bit 1 in the same cycle as a W1C of bit 1 → `o_value[1]`=1 and `o_overflow[1]`=0.
- W0C configuration (`CLEAR_VALUE`=0), flags 4'hF: write data 4'b1010, mask 4'hF → `o_value`=4'b1010. Same write with mask 0 → no change.
- LEVEL, FALLING and BOTH modes: drive `i_event[0]` through the sequence 0,1,1,0 and check that hits occur at the expected cycles (LEVEL: two; FALLING: one at the 1→0 edge; BOTH: two).
- With `RGGEN_STICKY_EVENT_SYNC_EN`: flag rises 3 cycles after an edge. Assert `rst_n` mid-pending → `o_value`=`INITIAL_VALUE`, `o_overflow`=0, `o_irq`=0 asynchronously.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for rggen bit-field primitives: event detection mode and the
// per-channel hit function used by the event detector.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_EVENT_LEVEL,
        RGGEN_EVENT_RISING,
        RGGEN_EVENT_FALLING,
        RGGEN_EVENT_BOTH
    } rggen_event_mode;

    function automatic logic event_hit(
        input rggen_event_mode mode,
        input logic            ev,
        input logic            prev
    );
        case (mode)
            RGGEN_EVENT_LEVEL:   return ev;
            RGGEN_EVENT_RISING:  return ev & ~prev;
            RGGEN_EVENT_FALLING: return ~ev & prev;
            default:             return ev ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register-to-bit-field access channel: the register drives access strobes and
// write data/mask, the bit field returns its current value and read data.
interface rggen_bit_field_if #(
    parameter int WIDTH = 1
);
    logic             read_access;
    logic             write_access;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] read_data;

    modport master (
        output read_access, write_access, write_data, write_mask,
        input  value, read_data
    );

    modport slave (
        input  read_access, write_access, write_data, write_mask,
        output value, read_data
    );
endinterface

// File: rtl/rggen_event_detector.sv
// Per-channel event detector producing a one-cycle hit vector.
// Optional 2-flop input synchronizer enabled by RGGEN_STICKY_EVENT_SYNC_EN.
module rggen_event_detector
    import rggen_rtl_pkg::*;
#(
    parameter rggen_event_mode EVENT_MODE = RGGEN_EVENT_RISING,
    parameter int              WIDTH      = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_event,
    output logic [WIDTH-1:0] o_hit
);

    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] prev;

`ifdef RGGEN_STICKY_EVENT_SYNC_EN
    logic [WIDTH-1:0] sync_q0;
    logic [WIDTH-1:0] sync_q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q0 <= '0;
            sync_q1 <= '0;
        end else begin
            // NOTE: non-blocking assignments let both stages sample the old values,
            // giving a true two-register chain instead of a single flop.
            sync_q0 <= i_event;
            sync_q1 <= sync_q0;
        end
    end

    assign ev = sync_q1;
`else
    assign ev = i_event;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= ev;
        end
    end

    always_comb begin
        // NOTE: the default assignment keeps every path of this block driven, so no latch is inferred.
        o_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_hit[i] = event_hit(EVENT_MODE, ev[i], prev[i]);
        end
    end

endmodule

// File: rtl/rggen_bit_field_sticky_event.sv
// Multi-channel sticky event flags with overflow tracking, software clear and a
// registered maskable interrupt. Input sync optional via RGGEN_STICKY_EVENT_SYNC_EN.
module rggen_bit_field_sticky_event
    import rggen_rtl_pkg::*;
#(
    parameter int              WIDTH         = 1,
    parameter rggen_event_mode EVENT_MODE    = RGGEN_EVENT_RISING,
    parameter logic            CLEAR_VALUE   = 1'b1,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i_event,
    input  logic [WIDTH-1:0]   i_irq_mask,
    rggen_bit_field_if.slave   bit_field_if,
    output logic [WIDTH-1:0]   o_value,
    output logic [WIDTH-1:0]   o_overflow,
    output logic               o_irq
);

    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] flag;
    logic [WIDTH-1:0] ovf;
    logic [WIDTH-1:0] next_flag;
    logic [WIDTH-1:0] next_ovf;
    logic             next_irq;

    rggen_event_detector #(
        .EVENT_MODE (EVENT_MODE),
        .WIDTH      (WIDTH)
    ) u_detector (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_event (i_event),
        .o_hit   (hit)
    );

    // Each channel is a three-state machine encoded as {ovf, flag}:
    // IDLE = 00, PENDING = 01, OVERFLOW = 11.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag  <= INITIAL_VALUE;
            ovf   <= '0;
            o_irq <= 1'b0;
        end else begin
            flag  <= next_flag;
            ovf   <= next_ovf;
            o_irq <= next_irq;
        end
    end

    always_comb begin
        clr = '0;
        if (bit_field_if.write_access) begin
            clr = bit_field_if.write_mask &
                  (CLEAR_VALUE ? bit_field_if.write_data : ~bit_field_if.write_data);
        end
        // A hit coinciding with a clear stays pending; the clear only wins for overflow.
        next_flag = hit | (flag & ~clr);
        next_ovf  = (hit & flag & ~clr) | (ovf & ~clr);
        next_irq  = |(next_flag & i_irq_mask);
    end

    assign o_value                = flag;
    assign o_overflow             = ovf;
    assign bit_field_if.value     = flag;
    assign bit_field_if.read_data = flag;

endmodule
